// File: rtl/tt_um_macros77_bcd2bin.sv
// 3-digit BCD to 10-bit binary converter using reverse double-dabble, one iteration per enabled clock.
// Optional macro BCD2BIN_ERR_EN: digits above 9 end the request at once with err=1 and bin=0.
module tt_um_macros77_bcd2bin (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state_reg, state_next;
  logic [21:0] sr_reg, sr_next;      // {hundreds, tens, ones, bin[9:0]}
  logic [3:0]  cnt_reg, cnt_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        start_q_reg;
  logic        armed_reg;
  logic        err;

  logic        start;
  logic        sel;
  logic        start_edge;
  logic [11:0] digits;
  logic [21:0] sr_shift;
  logic [21:0] sr_dabble;
  logic        unused_uio;

  assign start  = uio_in[4];
  assign sel    = uio_in[5];
  assign digits = {uio_in[3:0], ui_in[7:4], ui_in[3:0]};
  assign unused_uio = &{1'b0, uio_in[7:6]};

  // armed_reg stays low for the first enabled edge after reset, so a start
  // already high at release is loaded into start_q without triggering.
  assign start_edge = start & ~start_q_reg & armed_reg;

  assign sr_shift        = {1'b0, sr_reg[21:1]};
  assign sr_dabble[9:0]  = sr_shift[9:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_digit
      localparam int LSB = 10 + 4 * gi;
      assign sr_dabble[LSB+3:LSB] = sr_shift[LSB+3] ? (sr_shift[LSB+3:LSB] - 4'd3)
                                                    : sr_shift[LSB+3:LSB];
    end
  endgenerate

`ifdef BCD2BIN_ERR_EN
  logic err_reg, err_next;
  logic digit_bad;
  assign digit_bad = (digits[11:8] > 4'd9) | (digits[7:4] > 4'd9) | (digits[3:0] > 4'd9);
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    sr_next    = sr_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
`ifdef BCD2BIN_ERR_EN
    err_next   = err_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (start_edge) begin
          sr_next    = {digits, 10'b0};
          cnt_next   = 4'd0;
          busy_next  = 1'b1;
          done_next  = 1'b0;
          state_next = CONV;
`ifdef BCD2BIN_ERR_EN
          err_next   = 1'b0;
          if (digit_bad) begin
            sr_next    = 22'b0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            err_next   = 1'b1;
            state_next = DONE;
          end
`endif
        end
      end
      CONV: begin
        sr_next  = sr_dabble;
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'd9) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sr_reg      <= 22'b0;
      cnt_reg     <= 4'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      start_q_reg <= 1'b0;
      armed_reg   <= 1'b0;
`ifdef BCD2BIN_ERR_EN
      err_reg     <= 1'b0;
`endif
    end else if (ena) begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      cnt_reg     <= cnt_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      start_q_reg <= start;
      armed_reg   <= 1'b1;
`ifdef BCD2BIN_ERR_EN
      err_reg     <= err_next;
`endif
    end
  end

  assign uo_out  = sel ? {err, 5'b0, sr_reg[9:8]} : sr_reg[7:0];
  assign uio_out = {done_reg, busy_reg, 6'b0};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: doc/tt_um_macros77_bcd2bin.md
TT_UM_MACROS77_BCD2BIN -- requirements
Module: tt_um_macros77_bcd2bin

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port ena, input, 1, design enable; when 0, all state holds.
REQ-004 SHALL have port ui_in, input, 8: [7:4] tens BCD digit, [3:0] ones BCD digit.
REQ-005 SHALL have port uio_in, input, 8: [3:0] hundreds BCD digit, [4] start, [5] sel, [7:6] unused.
REQ-006 SHALL have port uo_out, output, 8: sel=0 gives bin[7:0]; sel=1 gives {err, 5'b0, bin[9:8]}; the mux is combinational on sel.
REQ-007 SHALL have port uio_out, output, 8: [7] done, [6] busy, [5:0] driven 0.
REQ-008 SHALL have port uio_oe, output, 8, constant 8'b1100_0000.

Function
REQ-009 SHALL convert a 3-digit BCD value (0..999) to a 10-bit binary bin using reverse double-dabble: 10 iterations of right shift, each followed by subtract 3 from any BCD digit >= 8.
REQ-010 SHALL have FSM states IDLE, CONV and DONE.
REQ-011 SHALL register start every enabled cycle (start_q) and define a start edge as start=1 with start_q=0.
REQ-012 SHALL, on a start edge in IDLE or DONE, capture the three digits, clear bin and the iteration counter, set busy=1, done=0, err=0 and enter CONV.
REQ-013 SHALL perform one iteration per enabled clock edge in CONV, on a 4-bit counter running 0..9.
REQ-014 SHALL, on the 10th CONV edge, write the final bin, set busy=0, done=1 and enter DONE; done is thus high after exactly 11 enabled edges, counting the start-edge capture.
REQ-015 SHALL ignore start edges while in CONV; no restart and no queued request.
REQ-016 SHALL hold bin and done stable in DONE until the next start edge; a start edge in DONE behaves as in IDLE.
REQ-017 SHALL treat start held high as one request; a new request needs start to return to 0 first.
REQ-018 SHALL leave bin[9:0] showing intermediate shift-register contents while busy=1; only done=1 qualifies bin.
REQ-019 SHALL, when ena=0, freeze FSM, counter, datapath and start_q; outputs keep their last values.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force state IDLE, bin=0, counter=0, start_q=0, busy=0, done=0, err=0, so uo_out=0 and uio_out=0.
REQ-021 SHALL, on reset asserted mid-conversion, abort the conversion with no result; after release it waits in IDLE for a fresh start edge, and a start already high at release does not trigger.

Configuration
REQ-022 SHALL have macro BCD2BIN_ERR_EN; when defined, any captured digit > 9 on a start edge sends the FSM straight to DONE on that edge with err=1, bin=0, done=1, busy=0.
REQ-023 SHALL, when BCD2BIN_ERR_EN is undefined, tie err to 0 and run invalid digits through the normal 10-iteration path; the result is unchecked.

Verification
REQ-024 SHALL cover: digits 0,0,0 with a start pulse -> done after 11 edges, uo_out=0x00 (sel=0), 0x00 (sel=1).
REQ-025 SHALL cover: digits 9,9,9 -> busy high for 10 edges, done, bin=0x3E7 (sel=0 gives 0xE7, sel=1 gives 0x03).
REQ-026 SHALL cover: 2,5,5 then 5,1,2 back-to-back (start pulsed in DONE) -> 0x0FF, then 0x200 (sel=1 gives 0x02); a start pulse injected mid-CONV leaves the result unchanged.
REQ-027 SHALL cover: start held high for 30 cycles with 1,2,3 -> exactly one conversion, bin=0x07B, no retrigger.
REQ-028 SHALL cover: rst_n pulsed low at iteration 5 of a 9,9,9 conversion -> all outputs 0 at once, IDLE until a new start edge.
REQ-029 SHALL cover, with BCD2BIN_ERR_EN: tens=0xA -> next edge done=1, err=1, sel=1 gives 0x80, sel=0 gives 0x00; a following valid 0,4,2 clears err and gives 0x02A.
